incr_pulse_debouncer: RTL and testbench
=======================================

// Module: incr_pulse_debouncer
// PURPOSE
//  Front end that feeds the mod-N counter's increment input.
//  - Synchronises a raw asynchronous level (push-button or external strobe) into clk_i.
//  - Debounces it with a 4-state FSM.
//  - Emits exactly one single-cycle incr_o pulse per qualified rising edge.
//  The downstream counter therefore sees clean, clock-aligned increments, never glitches or bounce.
// PARAMETERS
//  SYNC_STAGES      2  synchroniser flop count on btn_i; legal range >=2
//  DEBOUNCE_CYCLES  4  consecutive synced samples required to change level; legal range >=2
// PORTS
//  clk_i    input   1  single clock; all state updates on its rising edge
//  rst_i    input   1  asynchronous, active-high reset
//  clear_i  input   1  synchronous clear of FSM/debounce state; synchroniser not cleared
//  btn_i    input   1  raw asynchronous input level
//  incr_o   output  1  one-cycle pulse on each qualified rising edge; drives counter incr
//  level_o  output  1  debounced level of btn_i
// BEHAVIOUR
//  Reset (rst_i=1, async):
//  - Synchroniser flops=0, state=LOW, cnt=0, level_o=0, incr_o=0.
//  Synchroniser:
//  - s = btn_i delayed through SYNC_STAGES flops.
//  - Only s reaches the FSM; btn_i is never used directly.
//  Counter:
//  - cnt width $clog2(DEBOUNCE_CYCLES); no wrap, bounded by FSM.
//  FSM states: LOW, RISE, HIGH, FALL (registered). level_o=1 in HIGH and FALL only.
//  - LOW:  s=1 -> RISE, cnt=1; else stay, cnt=0.
//  - RISE: s=0 -> LOW, cnt=0 (bounce, no pulse).
//          s=1 & cnt==DEBOUNCE_CYCLES-1 -> HIGH, cnt=0, incr_o=1 next cycle.
//          s=1 otherwise -> cnt+1.
//  - HIGH: s=0 -> FALL, cnt=1; else stay.
//  - FALL: s=1 -> HIGH, cnt=0 (bounce, no pulse).
//          s=0 & cnt==DEBOUNCE_CYCLES-1 -> LOW, cnt=0.
//          s=0 otherwise -> cnt+1.
//  incr_o:
//  - Registered; high for exactly the one cycle after the RISE->HIGH transition.
//  - No pulse on falling edges or FALL->HIGH returns.
//  Latency: btn_i held high from first sampling edge E gives:
//  - incr_o=1 and level_o=1 after edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1 (6 edges total at defaults).
//  - Falling level_o takes the same latency.
//  clear_i=1 at an edge:
//  - state=LOW, cnt=0, level_o=0, incr_o=0; has priority over all FSM transitions.
//  - If s is still 1 after clear, the FSM requalifies from LOW and issues a new pulse after DEBOUNCE_CYCLES samples.
//  Reset mid-qualification:
//  - Aborts immediately; no pulse is issued for the aborted edge.
//  Max pulse rate: one per 2*DEBOUNCE_CYCLES cycles (minimum high + low qualification).
// TESTING (defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//  1 Reset, then btn_i=0 for 20 cycles -> incr_o=0, level_o=0 throughout.
//  2 btn_i 0->1 held -> incr_o high exactly 1 cycle, 6 edges after first high sample;
//    level_o=1 from the same cycle.
//  3 Bounce: btn_i high 3 cycles, low 1, high 3, low -> no incr_o, level_o stays 0.
//  4 Release bounce: from HIGH, btn_i low 2, high 2, low held -> level_o falls once after qualification;
//    no incr_o on release.
//  5 Chained with mod3_counter: 5 clean presses -> 5 incr_o pulses, counter reads 2 (5 mod 3).
//  6 clear_i pulse in RISE (cnt=2) with btn_i held -> no pulse at the original time;
//    one pulse 4 edges after clear. rst_i mid-RISE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/incr_pulse_debouncer.sv
// Synchronises and debounces a raw button/strobe level and emits one clean
// single-cycle increment pulse per qualified rising edge.
//
// state | meaning
// ------+-----------------------------------------------------------
// LOW   | debounced level 0, idle
// RISE  | synced input went high, counting consecutive high samples
// HIGH  | debounced level 1
// FALL  | synced input went low, counting consecutive low samples
module incr_pulse_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic btn_i,
    output logic incr_o,
    output logic level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   incr_q, incr_d;

    // clear_i deliberately leaves the synchroniser alone so a held input requalifies
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            incr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            incr_q  <= incr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        incr_d  = 1'b0;
        if (clear_i) begin
            state_d = ST_LOW;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_LOW: begin
                    if (s) begin
                        state_d = ST_RISE;
                        cnt_d   = CW'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end
                ST_RISE: begin
                    if (!s) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                        incr_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                ST_HIGH: begin
                    if (!s) begin
                        state_d = ST_FALL;
                        cnt_d   = CW'(1);
                    end
                end
                ST_FALL: begin
                    if (s) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        level_o = (state_q == ST_HIGH) || (state_q == ST_FALL);
        incr_o  = incr_q;
    end

endmodule

// File: tb/tb_incr_pulse_debouncer.sv
// Directed bench: stimulus pushes the cycle at which each incr_o pulse is due,
// a monitor pops and compares whenever incr_o is seen high.
module tb_incr_pulse_debouncer;

    logic clk_i = 1'b0;
    logic rst_i, clear_i, btn_i;
    logic incr_o, level_o;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int exp_q[$];
    int pulse_cnt_mod3 = 0;

    incr_pulse_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .btn_i   (btn_i),
        .incr_o  (incr_o),
        .level_o (level_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every observed pulse must match the next expected pulse cycle
    always @(negedge clk_i) begin
        if (incr_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_incr_pulse", cyc, -1);
            end else begin
                chk("incr_pulse_cycle", cyc, exp_q.pop_front());
            end
            pulse_cnt_mod3 = (pulse_cnt_mod3 + 1) % 3;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Press starting at current negedge; pulse due SYNC+DEB edges later
    task automatic press();
        btn_i = 1'b1;
        exp_q.push_back(cyc + 6);
    endtask

    initial begin
        int base;
        rst_i = 1'b1; clear_i = 1'b0; btn_i = 1'b0;
        tick(2);
        chk("reset_incr", incr_o, 0);
        chk("reset_level", level_o, 0);
        rst_i = 1'b0;

        // 1: idle input
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("idle_level", level_o, 0);
        end

        // 2: clean press, level and pulse at same cycle
        base = cyc;
        press();
        tick(5);
        chk("press_level_before", level_o, 0);
        tick(1);
        chk("press_level_after", level_o, 1);
        chk("press_incr_now", incr_o, 1);
        tick(1);
        chk("press_incr_one_cycle", incr_o, 0);
        tick(4);
        // clean release: same latency, no pulse
        btn_i = 1'b0;
        tick(5);
        chk("release_level_before", level_o, 1);
        tick(1);
        chk("release_level_after", level_o, 0);
        tick(6);

        // 3: rising bounce 3 high / 1 low / 3 high / low
        btn_i = 1'b1; tick(3);
        btn_i = 1'b0; tick(1);
        btn_i = 1'b1; tick(3);
        btn_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("bounce_level", level_o, 0);
        end

        // 4: release bounce from HIGH
        press();
        tick(10);
        chk("rb_high_level", level_o, 1);
        btn_i = 1'b0; tick(2);
        btn_i = 1'b1; tick(2);
        btn_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("rb_level_hold", level_o, 1);
        end
        tick(1);
        chk("rb_level_fall", level_o, 0);
        tick(6);

        // 5: five presses into a mod-3 counter
        pulse_cnt_mod3 = 0;
        for (int p = 0; p < 5; p++) begin
            press();
            tick(8);
            btn_i = 1'b0;
            tick(8);
        end
        chk("mod3_count", pulse_cnt_mod3, 2);

        // 6a: clear in RISE with cnt=2, held input requalifies
        base = cyc;
        btn_i = 1'b1;
        tick(4);
        clear_i = 1'b1;
        exp_q.push_back(base + 9);
        tick(1);
        clear_i = 1'b0;
        tick(1);
        chk("clear_no_orig_pulse", incr_o, 0);
        chk("clear_level_low", level_o, 0);
        tick(3);
        chk("clear_requal_level", level_o, 1);
        tick(3);
        btn_i = 1'b0;
        tick(12);

        // 6b: async reset mid-RISE
        btn_i = 1'b1;
        tick(4);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_async_incr", incr_o, 0);
        chk("rst_async_level", level_o, 0);
        tick(1);
        rst_i = 1'b0;
        exp_q.push_back(cyc + 6);
        tick(5);
        chk("rst_no_aborted_pulse_level", level_o, 0);
        tick(4);
        btn_i = 1'b0;
        tick(12);

        chk("pending_pulses", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
